// File: rtl/mesi_pkg.sv
// Shared types and state encodings for the MESI line tracker.
package mesi_pkg;

  typedef enum logic [1:0] {
    MODIFIED  = 2'd0,
    EXCLUSIVE = 2'd1,
    SHARED    = 2'd2,
    INVALID   = 2'd3
  } mesi_state_t;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_RD   = 2'd1,
    BUS_RDX  = 2'd2
  } bus_req_t;

  localparam logic [1:0] ST_M = 2'd0;
  localparam logic [1:0] ST_E = 2'd1;
  localparam logic [1:0] ST_S = 2'd2;
  localparam logic [1:0] ST_I = 2'd3;

endpackage

// File: rtl/mesi_line_next.sv
// Combinational MESI transition for one line: snoop applied first, then the
// processor request is evaluated against the post-snoop state.
module mesi_line_next
  import mesi_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       snp_valid_i,
  input  logic       snp_write_i,
  input  logic       pr_valid_i,
  input  logic       pr_write_i,
  input  logic       pr_shared_i,
  output logic [1:0] post_snp_o,
  output logic [1:0] next_o,
  output logic       hit_o,
  output logic       bus_req_o,
  output logic       excl_o,
  output logic       flush_o
);

  mesi_state_t cur;
  mesi_state_t post;
  mesi_state_t nxt;
  bus_req_t    kind;

  assign cur = mesi_state_t'(cur_i);

  always_comb begin
    post    = cur;
    flush_o = 1'b0;
    if (snp_valid_i) begin
      case (cur)
        MODIFIED: begin
          post    = snp_write_i ? INVALID : SHARED;
          flush_o = 1'b1;
        end
        EXCLUSIVE: post = snp_write_i ? INVALID : SHARED;
        SHARED:    post = snp_write_i ? INVALID : SHARED;
        default:   post = INVALID;
      endcase
    end
  end

  always_comb begin
    nxt   = post;
    hit_o = 1'b0;
    kind  = BUS_NONE;
    if (pr_valid_i) begin
      case (post)
        INVALID: begin
          if (pr_write_i) begin
            nxt  = MODIFIED;
            kind = BUS_RDX;
          end else begin
            nxt  = pr_shared_i ? SHARED : EXCLUSIVE;
            kind = BUS_RD;
          end
        end
        SHARED: begin
          if (pr_write_i) begin
            nxt  = MODIFIED;
            kind = BUS_RDX;
          end else begin
            hit_o = 1'b1;
          end
        end
        EXCLUSIVE: begin
          hit_o = 1'b1;
          if (pr_write_i) nxt = MODIFIED;
        end
        default: hit_o = 1'b1;
      endcase
    end
  end

  assign post_snp_o = post;
  assign next_o     = nxt;
  assign bus_req_o  = (kind != BUS_NONE);
  assign excl_o     = (kind == BUS_RDX);

endmodule

// File: rtl/mesi_line_table.sv
// Per-line MESI state table for one private cache: one processor request and
// one snoop per cycle, registered responses and a running dirty-line count.
module mesi_line_table
  import mesi_pkg::*;
#(
  parameter  int NUM_LINES = 8,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int CNT_W     = $clog2(NUM_LINES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pr_valid,
  input  logic             pr_write,
  input  logic [IDX_W-1:0] pr_index,
  input  logic             pr_shared,
  input  logic             snp_valid,
  input  logic             snp_write,
  input  logic [IDX_W-1:0] snp_index,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [1:0]       rsp_state,
  output logic             bus_req_valid,
  output logic             bus_req_excl,
  output logic             snp_rsp_valid,
  output logic             snp_shared,
  output logic             snp_flush,
  output logic [CNT_W-1:0] dirty_count
);

  localparam logic [IDX_W:0] LIMIT = NUM_LINES[IDX_W:0];
  localparam logic [CNT_W:0] ONE   = {{CNT_W{1'b0}}, 1'b1};

  logic [1:0]       lines_q [NUM_LINES];
  logic [1:0]       lines_d [NUM_LINES];
  logic [CNT_W-1:0] dirty_q, dirty_d;
  logic [CNT_W:0]   dirty_sum;

  logic       rsp_valid_q, rsp_hit_q, bus_req_valid_q, bus_req_excl_q;
  logic [1:0] rsp_state_q;
  logic       snp_rsp_valid_q, snp_shared_q, snp_flush_q;

  logic       snp_in_rng, pr_in_rng, snp_eff, pr_eff, same_idx;
  logic [1:0] snp_cur, pr_raw, pr_cur;
  logic [1:0] snp_post, snp_next, pr_post, pr_next;
  logic       snp_hit, snp_bus, snp_excl, snp_flush_c;
  logic       pr_hit, pr_bus, pr_excl, pr_flush;

  assign snp_in_rng = ({1'b0, snp_index} < LIMIT);
  assign pr_in_rng  = ({1'b0, pr_index} < LIMIT);
  assign snp_eff    = snp_valid && snp_in_rng;
  assign pr_eff     = pr_valid && pr_in_rng;
  assign same_idx   = (snp_index == pr_index);

  always_comb begin
    snp_cur = ST_I;
    pr_raw  = ST_I;
    if (snp_in_rng) snp_cur = lines_q[snp_index];
    if (pr_in_rng)  pr_raw  = lines_q[pr_index];
  end

  // A same-cycle snoop to the same line is seen by the processor request.
  assign pr_cur = (snp_eff && same_idx) ? snp_post : pr_raw;

  mesi_line_next u_snp (
    .cur_i       (snp_cur),
    .snp_valid_i (snp_eff),
    .snp_write_i (snp_write),
    .pr_valid_i  (1'b0),
    .pr_write_i  (1'b0),
    .pr_shared_i (1'b0),
    .post_snp_o  (snp_post),
    .next_o      (snp_next),
    .hit_o       (snp_hit),
    .bus_req_o   (snp_bus),
    .excl_o      (snp_excl),
    .flush_o     (snp_flush_c)
  );

  mesi_line_next u_pr (
    .cur_i       (pr_cur),
    .snp_valid_i (1'b0),
    .snp_write_i (1'b0),
    .pr_valid_i  (pr_eff),
    .pr_write_i  (pr_write),
    .pr_shared_i (pr_shared),
    .post_snp_o  (pr_post),
    .next_o      (pr_next),
    .hit_o       (pr_hit),
    .bus_req_o   (pr_bus),
    .excl_o      (pr_excl),
    .flush_o     (pr_flush)
  );

  logic unused_ok;
  assign unused_ok = ^{snp_hit, snp_bus, snp_excl, pr_post, pr_flush};

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      lines_d[i] = lines_q[i];
      if (snp_eff && (snp_index == IDX_W'(i))) lines_d[i] = snp_next;
      if (pr_eff && (pr_index == IDX_W'(i)))   lines_d[i] = pr_next;
    end
  end

  // Net change in MODIFIED lines; an overlapping pair counts as one line.
  always_comb begin
    dirty_sum = {1'b0, dirty_q};
    if (pr_eff) begin
      if (pr_raw == ST_M)  dirty_sum = dirty_sum - ONE;
      if (pr_next == ST_M) dirty_sum = dirty_sum + ONE;
    end
    if (snp_eff && !(pr_eff && same_idx)) begin
      if (snp_cur == ST_M)  dirty_sum = dirty_sum - ONE;
      if (snp_next == ST_M) dirty_sum = dirty_sum + ONE;
    end
    dirty_d = dirty_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= ST_I;
      dirty_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_state_q     <= ST_I;
      bus_req_valid_q <= 1'b0;
      bus_req_excl_q  <= 1'b0;
      snp_rsp_valid_q <= 1'b0;
      snp_shared_q    <= 1'b0;
      snp_flush_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= lines_d[i];
      dirty_q         <= dirty_d;
      rsp_valid_q     <= pr_valid;
      rsp_hit_q       <= pr_eff && pr_hit;
      rsp_state_q     <= pr_eff ? pr_next : ST_I;
      bus_req_valid_q <= pr_eff && pr_bus;
      bus_req_excl_q  <= pr_eff && pr_excl;
      snp_rsp_valid_q <= snp_valid;
      snp_shared_q    <= snp_eff && (snp_cur != ST_I);
      snp_flush_q     <= snp_eff && snp_flush_c;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_state     = rsp_state_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_req_excl  = bus_req_excl_q;
  assign snp_rsp_valid = snp_rsp_valid_q;
  assign snp_shared    = snp_shared_q;
  assign snp_flush     = snp_flush_q;
  assign dirty_count   = dirty_q;

endmodule
